// File: rtl/mesi_isc_cbus_snoop.sv
// Snoop responder for one CPU on the MESI coherence bus: looks up a small
// direct-mapped line table, issues write-backs for Modified lines, grants
// local read/write enables, and acknowledges each bus command exactly once.
module mesi_isc_cbus_snoop #(
  parameter int unsigned CBUS_CMD_WIDTH = 3,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LINES          = 4,
  parameter int unsigned LINES_LOG2     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  output logic                      cbus_ack_o,
  input  logic                      upd_valid_i,
  input  logic [ADDR_WIDTH-1:0]     upd_addr_i,
  input  logic [1:0]                upd_state_i,
  output logic                      wb_valid_o,
  output logic [ADDR_WIDTH-1:0]     wb_addr_o,
  input  logic                      wb_ready_i,
  output logic                      en_wr_o,
  output logic                      en_rd_o
);

  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_NOP      = CBUS_CMD_WIDTH'(0);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

  localparam logic [1:0] LS_I = 2'd0;
  localparam logic [1:0] LS_S = 2'd1;
  localparam logic [1:0] LS_E = 2'd2;
  localparam logic [1:0] LS_M = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WB     = 3'd2,
    ST_ACK    = 3'd3,
    ST_GAP    = 3'd4
  } fsm_e;

  fsm_e                      state_q, state_d;
  logic [CBUS_CMD_WIDTH-1:0] cmd_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [ADDR_WIDTH-1:0]     line_addr_q  [LINES];
  logic [1:0]                line_state_q [LINES];

  logic [LINES_LOG2-1:0] snp_idx;
  logic [LINES_LOG2-1:0] upd_idx;
  logic                  hit;
  logic [1:0]            hit_state;
  logic                  snp_wr;
  logic [1:0]            snp_state;

  // Line index and hit detection for the latched snoop address.
  always_comb begin
    snp_idx   = addr_q[LINES_LOG2+1:2];
    upd_idx   = upd_addr_i[LINES_LOG2+1:2];
    hit_state = line_state_q[snp_idx];
    hit       = (line_addr_q[snp_idx] == addr_q) && (hit_state != LS_I);
  end

  // Next-state logic and the snoop-side line state write.
  always_comb begin
    state_d   = state_q;
    snp_wr    = 1'b0;
    snp_state = LS_I;
    case (state_q)
      ST_IDLE: begin
        if (cbus_cmd_i != CMD_NOP) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        state_d = ST_ACK;
        case (cmd_q)
          CMD_WR_SNOOP: begin
            if (hit) begin
              if (hit_state == LS_M) begin
                state_d = ST_WB;
              end else begin
                snp_wr    = 1'b1;
                snp_state = LS_I;
              end
            end
          end
          CMD_RD_SNOOP: begin
            if (hit) begin
              if (hit_state == LS_M) begin
                state_d = ST_WB;
              end else if (hit_state == LS_E) begin
                snp_wr    = 1'b1;
                snp_state = LS_S;
              end
            end
          end
          default: ;
        endcase
      end
      ST_WB: begin
        if (wb_ready_i) begin
          state_d   = ST_ACK;
          snp_wr    = 1'b1;
          snp_state = (cmd_q == CMD_WR_SNOOP) ? LS_I : LS_S;
        end
      end
      ST_ACK:  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM register, command latch and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      cbus_ack_o <= 1'b0;
      wb_valid_o <= 1'b0;
      wb_addr_o  <= '0;
      en_wr_o    <= 1'b0;
      en_rd_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && (cbus_cmd_i != CMD_NOP)) begin
        cmd_q  <= cbus_cmd_i;
        addr_q <= cbus_addr_i;
      end
      cbus_ack_o <= (state_d == ST_ACK);
      wb_valid_o <= (state_d == ST_WB);
      wb_addr_o  <= (state_d == ST_WB) ? addr_q : '0;
      en_wr_o    <= (state_q == ST_IDLE) && (cbus_cmd_i == CMD_EN_WR);
      en_rd_o    <= (state_q == ST_IDLE) && (cbus_cmd_i == CMD_EN_RD);
    end
  end

  // Line table: local updates, overridden by a snoop change on the same index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(LINES); i++) begin
        line_addr_q[i]  <= '0;
        line_state_q[i] <= LS_I;
      end
    end else begin
      if (upd_valid_i && !(snp_wr && (upd_idx == snp_idx))) begin
        line_addr_q[upd_idx]  <= upd_addr_i;
        line_state_q[upd_idx] <= upd_state_i;
      end
      if (snp_wr) line_state_q[snp_idx] <= snp_state;
    end
  end

endmodule

// File: tb/tb_mesi_isc_cbus_snoop.sv
// Bench for mesi_isc_cbus_snoop: transaction-level line-table model drives
// per-cycle output expectations; directed scenarios plus random traffic.
module tb_mesi_isc_cbus_snoop;

  localparam int unsigned CW = 3;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cbus_cmd;
  logic [AW-1:0] cbus_addr;
  logic          cbus_ack;
  logic          upd_valid;
  logic [AW-1:0] upd_addr;
  logic [1:0]    upd_state;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic          wb_ready;
  logic          en_wr;
  logic          en_rd;

  mesi_isc_cbus_snoop #(
    .CBUS_CMD_WIDTH(CW), .ADDR_WIDTH(AW), .LINES(4), .LINES_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst),
    .cbus_cmd_i(cbus_cmd), .cbus_addr_i(cbus_addr), .cbus_ack_o(cbus_ack),
    .upd_valid_i(upd_valid), .upd_addr_i(upd_addr), .upd_state_i(upd_state),
    .wb_valid_o(wb_valid), .wb_addr_o(wb_addr), .wb_ready_i(wb_ready),
    .en_wr_o(en_wr), .en_rd_o(en_rd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int ack_lat  = -1;
  int wb_cycles = 0;

  logic          chk_en = 1'b0;
  logic          exp_ack, exp_wbv, exp_enw, exp_enr;
  logic [AW-1:0] exp_wba;

  // Model: per-line address and MESI state (I=0 S=1 E=2 M=3).
  logic [AW-1:0] m_addr  [4];
  logic [1:0]    m_state [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Compare process: every cycle against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cbus_ack", 64'(cbus_ack), 64'(exp_ack));
      chk("wb_valid", 64'(wb_valid), 64'(exp_wbv));
      chk("en_wr", 64'(en_wr), 64'(exp_enw));
      chk("en_rd", 64'(en_rd), 64'(exp_enr));
      if (exp_wbv) chk("wb_addr", 64'(wb_addr), 64'(exp_wba));
      if (cbus_ack) ack_lat = cyc - t0;
      if (wb_valid) wb_cycles++;
    end
  end

  task automatic next_cycle(input bit garbage);
    @(posedge clk); #1;
    exp_ack = 1'b0; exp_wbv = 1'b0; exp_enw = 1'b0; exp_enr = 1'b0; exp_wba = '0;
    upd_valid = 1'b0;
    upd_addr  = $urandom;
    upd_state = 2'($urandom);
    wb_ready  = 1'($urandom);
    cbus_cmd  = garbage ? CW'($urandom) : '0;
    cbus_addr = $urandom;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_addr[i]  = '0;
      m_state[i] = 2'd0;
    end
  endtask

  task automatic idle_upd(input logic [AW-1:0] a, input logic [1:0] s);
    next_cycle(1'b0);
    upd_valid = 1'b1; upd_addr = a; upd_state = s;
    m_addr[a[3:2]]  = a;
    m_state[a[3:2]] = s;
  endtask

  // One full bus command from IDLE through GAP.
  task automatic run_cmd(input logic [CW-1:0] cmd, input logic [AW-1:0] addr,
                         input int wbd, input bit do_upd,
                         input logic [AW-1:0] ua, input logic [1:0] us);
    int         idx;
    logic       hit, wb, chg;
    logic [1:0] ns;
    idx = int'(addr[3:2]);
    next_cycle(1'b0);
    cbus_cmd = cmd; cbus_addr = addr;
    t0 = cyc; ack_lat = -1; wb_cycles = 0;
    hit = (m_addr[idx] == addr) && (m_state[idx] != 2'd0);
    wb  = (cmd == 1 || cmd == 2) && hit && (m_state[idx] == 2'd3);
    chg = 1'b0; ns = 2'd0;
    if (cmd == 1 && hit && !wb) begin chg = 1'b1; ns = 2'd0; end
    if (cmd == 2 && hit && m_state[idx] == 2'd2) begin chg = 1'b1; ns = 2'd1; end
    // lookup cycle
    next_cycle(1'b1);
    exp_enw = (cmd == 3);
    exp_enr = (cmd == 4);
    if (do_upd) begin
      upd_valid = 1'b1; upd_addr = ua; upd_state = us;
      if (!(chg && int'(ua[3:2]) == idx)) begin
        m_addr[ua[3:2]]  = ua;
        m_state[ua[3:2]] = us;
      end
    end
    if (chg) m_state[idx] = ns;
    if (wb) begin
      for (int k = 0; k <= wbd; k++) begin
        next_cycle(1'b1);
        exp_wbv = 1'b1; exp_wba = addr;
        wb_ready = (k == wbd);
      end
      m_state[idx] = (cmd == 1) ? 2'd0 : 2'd1;
    end
    next_cycle(1'b1);
    exp_ack = 1'b1;
    next_cycle(1'b1);
  endtask

  function automatic logic [AW-1:0] pool_addr();
    return AW'((($urandom % 4) << 8) | (($urandom % 4) << 2));
  endfunction

  initial begin
    rst = 1'b0; cbus_cmd = '0; cbus_addr = '0; upd_valid = 1'b0;
    upd_addr = '0; upd_state = '0; wb_ready = 1'b0;
    exp_ack = 1'b0; exp_wbv = 1'b0; exp_enw = 1'b0; exp_enr = 1'b0; exp_wba = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_wb_addr", 64'(wb_addr), 64'h0);
    chk("reset_ack", 64'(cbus_ack), 64'h0);
    next_cycle(1'b0);
    rst = 1'b1;

    // Modified line, write snoop, ready after 3 cycles
    idle_upd(32'h100, 2'd3);
    run_cmd(3'd1, 32'h100, 3, 1'b0, '0, '0);
    chk("m_wr_snoop_ack_lat", 64'(ack_lat), 64'd6);
    chk("m_wr_snoop_wb_cycles", 64'(wb_cycles), 64'd4);
    run_cmd(3'd1, 32'h100, 0, 1'b0, '0, '0);
    chk("after_wb_line_inv", 64'(wb_cycles), 64'd0);

    // Exclusive line, read snoop twice
    idle_upd(32'h204, 2'd2);
    run_cmd(3'd2, 32'h204, 0, 1'b0, '0, '0);
    chk("e_rd_snoop_ack_lat", 64'(ack_lat), 64'd2);
    run_cmd(3'd2, 32'h204, 0, 1'b0, '0, '0);
    chk("s_rd_snoop_ack_lat", 64'(ack_lat), 64'd2);

    // Local grants
    run_cmd(3'd3, 32'h40, 0, 1'b0, '0, '0);
    chk("en_wr_ack_lat", 64'(ack_lat), 64'd2);
    run_cmd(3'd4, 32'h40, 0, 1'b0, '0, '0);
    chk("en_rd_ack_lat", 64'(ack_lat), 64'd2);

    // Miss keeps the stored Modified line
    idle_upd(32'h300, 2'd3);
    run_cmd(3'd1, 32'h310, 0, 1'b0, '0, '0);
    chk("miss_no_wb", 64'(wb_cycles), 64'd0);
    run_cmd(3'd1, 32'h300, 1, 1'b0, '0, '0);
    chk("miss_state_kept_wb", 64'(wb_cycles), 64'd2);

    // Snoop invalidate beats a same-cycle local update
    idle_upd(32'h8, 2'd2);
    run_cmd(3'd1, 32'h8, 0, 1'b1, 32'h8, 2'd3);
    run_cmd(3'd1, 32'h8, 0, 1'b0, '0, '0);
    chk("snoop_wins_no_wb", 64'(wb_cycles), 64'd0);

    // Undefined command code
    run_cmd(3'd6, 32'h104, 0, 1'b0, '0, '0);
    chk("undef_cmd_ack_lat", 64'(ack_lat), 64'd2);

    // Reset while a write-back is pending
    idle_upd(32'h100, 2'd3);
    next_cycle(1'b0);
    cbus_cmd = 3'd1; cbus_addr = 32'h100;
    next_cycle(1'b1);
    next_cycle(1'b1); exp_wbv = 1'b1; exp_wba = 32'h100; wb_ready = 1'b0;
    next_cycle(1'b1); exp_wbv = 1'b1; exp_wba = 32'h100; wb_ready = 1'b0; rst = 1'b0;
    model_clear();
    next_cycle(1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort_wb_valid", 64'(wb_valid), 64'h0);
    chk("rst_abort_ack", 64'(cbus_ack), 64'h0);
    run_cmd(3'd2, 32'h100, 0, 1'b0, '0, '0);
    chk("post_rst_rd_ack_lat", 64'(ack_lat), 64'd2);
    chk("post_rst_no_wb", 64'(wb_cycles), 64'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom % 4 == 0) begin
        idle_upd(pool_addr(), 2'($urandom));
      end else begin
        run_cmd(CW'(1 + $urandom % 7), pool_addr(), int'($urandom % 4),
                ($urandom % 3) == 0, pool_addr(), 2'($urandom));
      end
    end

    next_cycle(1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mesi_isc_cbus_snoop.md
MESI_ISC_CBUS_SNOOP -- requirements
Module: mesi_isc_cbus_snoop

Interface
REQ-001 Parameter CBUS_CMD_WIDTH, default 3, width of the coherence bus command.
REQ-002 Parameter ADDR_WIDTH, default 32, coherence bus address width.
REQ-003 Parameter LINES, default 4, number of tracked local lines; LINES_LOG2, default 2.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low.
REQ-006 cbus_cmd_i  input  CBUS_CMD_WIDTH  command for this CPU: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4.
REQ-007 cbus_addr_i  input  ADDR_WIDTH  coherence bus address, valid while cbus_cmd_i != NOP.
REQ-008 cbus_ack_o  output  1  single-cycle acknowledge for the current command.
REQ-009 upd_valid_i / upd_addr_i[ADDR_WIDTH] / upd_state_i[2]  input  local cache line fill or state update.
REQ-010 wb_valid_o  output  1; wb_addr_o  output  ADDR_WIDTH: write-back request for a Modified line.
REQ-011 wb_ready_i  input  1  write-back accepted when wb_valid_o && wb_ready_i.
REQ-012 en_wr_o, en_rd_o  output  1 each  single-cycle grants to the local CPU for its pending write/read.

Function
REQ-013 Line state encoding: I=0, S=1, E=2, M=3; per line, a stored address and state.
REQ-014 Index = addr[LINES_LOG2+1:2]; hit = stored address == cbus_addr_i and state != I.
REQ-015 FSM states: IDLE, LOOKUP, WB, ACK, GAP.
REQ-016 IDLE: cbus_cmd_i != NOP -> latch cmd/addr, go to LOOKUP; NOP -> stay.
REQ-017 LOOKUP, WR_SNOOP: hit M -> WB; hit E/S -> line set to I, go to ACK; miss -> ACK.
REQ-018 LOOKUP, RD_SNOOP: hit M -> WB; hit E -> line set to S, go to ACK; hit S or miss -> ACK.
REQ-019 LOOKUP, EN_WR: pulse en_wr_o for 1 cycle, go to ACK; EN_RD: pulse en_rd_o, go to ACK.
REQ-020 LOOKUP with an undefined command code (5-7) -> ACK, with no state change and no grant.
REQ-021 WB: wb_valid_o=1, wb_addr_o=latched address, both held stable until wb_ready_i; at the handshake the line goes to I (WR_SNOOP) or S (RD_SNOOP), then ACK.
REQ-022 ACK: cbus_ack_o=1 for exactly one cycle, then GAP.
REQ-023 GAP: one cycle ignoring cbus_cmd_i (the controller drops the command after ack), then IDLE.
REQ-024 Latency without write-back: command sampled in IDLE at cycle 0, ack at cycle 2.
REQ-025 Latency with write-back: ack 1 cycle after the wb handshake cycle.
REQ-026 upd_valid_i writes the indexed line's address/state in any FSM state.
REQ-027 If a snoop state change and upd_valid_i hit the same index in the same cycle, the snoop result wins.
REQ-028 The latched address/command are not affected by changes of cbus_addr_i/cbus_cmd_i after IDLE.
REQ-029 The block accepts at most one outstanding command; there is no queueing.

Reset
REQ-030 With rst=0 at a clock edge: FSM to IDLE, all line states to I, stored addresses to 0.
REQ-031 Reset values of outputs: cbus_ack_o, wb_valid_o, wb_addr_o, en_wr_o, en_rd_o all 0.
REQ-032 Reset during WB or ACK aborts the operation: no ack, wb_valid_o is 0 in the next cycle.

Verification
REQ-033 Line 0x100 in M, then WR_SNOOP 0x100 -> wb_valid_o with wb_addr_o=0x100; wb_ready_i after 3 cycles -> ack 1 cycle later; line goes to I.
REQ-034 Line 0x204 in E, then RD_SNOOP 0x204 -> no write-back; ack at cycle 2; line goes to S; a repeat RD_SNOOP gives ack with S unchanged.
REQ-035 EN_WR with addr 0x40 -> en_wr_o pulse at cycle 1 and ack at cycle 2; EN_RD -> en_rd_o pulse; no line change.
REQ-036 WR_SNOOP miss (stored 0x300, snoop 0x310) -> ack at cycle 2, no write-back, state kept.
REQ-037 WR_SNOOP on E line 0x8 together with upd_valid_i (0x8, M) in the LOOKUP cycle -> line ends in I.
REQ-038 rst=0 while wb_valid_o=1 -> next cycle wb_valid_o=0 and cbus_ack_o=0, all lines I; a new RD_SNOOP completes with ack at cycle 2.
